// File: rtl/ml_if_buffer.sv
`default_nettype none
// ============================================================================
// Module   : ml_if_buffer
// Purpose  : Input-feature staging buffer between the activation SRAM and the
//            PE array. A load request bursts DEPTH words from SRAM into a local
//            FIFO. A drain request then streams them, one word per cycle, to
//            the PE input register files.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            i_if_fifo_ctrl[1:0] - [0] load request, [1] drain request (level)
//            o_if_fifo_resp[1:0] - [0] buffer full / load done, [1] drain done
//            i_base_addr         - SRAM start address, sampled on load start
//            o_sram_rd_en/addr   - SRAM read strobe and word address
//            i_sram_rd_data      - SRAM read data, valid 1 cycle after strobe
//            o_pe_if_data/valid  - registered word to PE RF, with qualifier
//            o_pe_if_idx         - PE row index of o_pe_if_data
//            o_count             - words currently held
//            o_err/o_err_code    - only when IF_BUF_ERR_CHK_EN is defined
// Config   : IF_BUF_ERR_CHK_EN - adds sticky protocol-error reporting
// Revision : 1.0 - initial release
// ============================================================================
module ml_if_buffer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 15,
  parameter int ADDR_W = 10,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        i_if_fifo_ctrl,
  output logic [1:0]        o_if_fifo_resp,
  input  logic [ADDR_W-1:0] i_base_addr,
  output logic              o_sram_rd_en,
  output logic [ADDR_W-1:0] o_sram_rd_addr,
  input  logic [DATA_W-1:0] i_sram_rd_data,
  output logic [DATA_W-1:0] o_pe_if_data,
  output logic              o_pe_if_valid,
  output logic [IDX_W-1:0]  o_pe_if_idx,
  output logic [IDX_W:0]    o_count
`ifdef IF_BUF_ERR_CHK_EN
  ,
  output logic              o_err,
  output logic [1:0]        o_err_code
`endif
);

  localparam logic [IDX_W-1:0] c_LAST    = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] c_ONE_IDX = IDX_W'(1);
  localparam logic [IDX_W:0]   c_ONE_CNT = (IDX_W+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_LWAIT = 3'd2,
    S_FULL  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_base;
  logic [IDX_W-1:0]    r_iss;       // next burst index to issue in LOAD
  logic                r_wr_pend;   // a strobe was issued last cycle
  logic [IDX_W-1:0]    r_wr_ptr;
  logic [IDX_W-1:0]    r_rd_ptr;
  logic [IDX_W:0]      r_count;
  logic [IDX_W-1:0]    r_out_idx;   // row index of the next word to drain
  logic                r_full;
  logic                r_done;
  logic [DATA_W-1:0]   r_data;
  logic                r_valid;
  logic [IDX_W-1:0]    r_idx;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_load_start;
  logic                w_pop;

  // The first strobe goes out in the same cycle the load request is seen,
  // so the IDLE-cycle address comes straight from i_base_addr.
  assign w_load_start   = (r_state == S_IDLE) && i_if_fifo_ctrl[0];
  assign w_pop          = ((r_state == S_FULL) || (r_state == S_DRAIN)) && i_if_fifo_ctrl[1];

  assign o_sram_rd_en   = !rst && (w_load_start || (r_state == S_LOAD));
  assign o_sram_rd_addr = !o_sram_rd_en ? '0 :
                          (w_load_start ? i_base_addr : r_base + ADDR_W'(r_iss));

  assign o_if_fifo_resp = {r_done, r_full};
  assign o_pe_if_data   = r_data;
  assign o_pe_if_valid  = r_valid;
  assign o_pe_if_idx    = r_idx;
  assign o_count        = r_count;

  // Storage carries no reset; r_count and the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && r_wr_pend) begin
      r_mem[r_wr_ptr] <= i_sram_rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_base    <= '0;
      r_iss     <= '0;
      r_wr_pend <= 1'b0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_out_idx <= '0;
      r_full    <= 1'b0;
      r_done    <= 1'b0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_idx     <= '0;
    end else begin
      r_valid   <= 1'b0;
      r_wr_pend <= o_sram_rd_en;

      // Read data lands one cycle after each strobe; load and drain never
      // overlap, so a write and a pop cannot occur in the same cycle.
      if (r_wr_pend) begin
        r_wr_ptr <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + c_ONE_IDX;
        r_count  <= r_count + c_ONE_CNT;
      end else if (w_pop) begin
        r_count  <= r_count - c_ONE_CNT;
      end

      if (w_pop) begin
        r_data   <= r_mem[r_rd_ptr];
        r_valid  <= 1'b1;
        r_idx    <= r_out_idx;
        r_rd_ptr <= (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + c_ONE_IDX;
        r_full   <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (i_if_fifo_ctrl[0]) begin
            r_base  <= i_base_addr;
            r_iss   <= c_ONE_IDX;
            r_done  <= 1'b0;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (r_iss == c_LAST) begin
            r_state <= S_LWAIT;
          end else begin
            r_iss <= r_iss + c_ONE_IDX;
          end
        end
        S_LWAIT: begin
          r_full  <= 1'b1;
          r_state <= S_FULL;
        end
        S_FULL, S_DRAIN: begin
          if (w_pop) begin
            if (r_out_idx == c_LAST) begin
              r_out_idx <= '0;
              r_done    <= 1'b1;
              r_state   <= S_IDLE;
            end else begin
              r_out_idx <= r_out_idx + c_ONE_IDX;
              r_state   <= S_DRAIN;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef IF_BUF_ERR_CHK_EN
  logic       r_err;
  logic [1:0] r_err_code;
  logic       w_err_drain_empty;
  logic       w_err_load_busy;

  // Drain with nothing held, or load while the buffer still holds a burst.
  assign w_err_drain_empty = (r_state == S_IDLE) && (i_if_fifo_ctrl == 2'b10) && (r_count == '0);
  assign w_err_load_busy   = ((r_state == S_FULL) || (r_state == S_DRAIN)) && i_if_fifo_ctrl[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err      <= 1'b0;
      r_err_code <= 2'b00;
    end else if (!r_err) begin
      if (w_err_drain_empty) begin
        r_err      <= 1'b1;
        r_err_code <= 2'b01;
      end else if (w_err_load_busy) begin
        r_err      <= 1'b1;
        r_err_code <= 2'b10;
      end
    end
  end

  assign o_err      = r_err;
  assign o_err_code = r_err_code;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ml_if_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ml_if_buffer
// Purpose  : Scoreboard bench for ml_if_buffer. Stimulus pushes expected SRAM
//            strobes and PE beats (with the cycle they are due) into queues;
//            a negedge monitor pops and compares whenever the DUT presents one.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ml_if_buffer;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 15;
  localparam int ADDR_W = 10;
  localparam int IDX_W  = 4;
  localparam int ASPACE = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        ctrl;
  logic [1:0]        resp;
  logic [ADDR_W-1:0] base;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] pe_data;
  logic              pe_valid;
  logic [IDX_W-1:0]  pe_idx;
  logic [IDX_W:0]    count;
`ifdef IF_BUF_ERR_CHK_EN
  logic              err;
  logic [1:0]        err_code;
`endif

  ml_if_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .IDX_W(IDX_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_if_fifo_ctrl(ctrl),
    .o_if_fifo_resp(resp),
    .i_base_addr   (base),
    .o_sram_rd_en  (rd_en),
    .o_sram_rd_addr(rd_addr),
    .i_sram_rd_data(rd_data),
    .o_pe_if_data  (pe_data),
    .o_pe_if_valid (pe_valid),
    .o_pe_if_idx   (pe_idx),
    .o_count       (count)
`ifdef IF_BUF_ERR_CHK_EN
    ,
    .o_err         (err),
    .o_err_code    (err_code)
`endif
  );

  always #5 clk = ~clk;

  // SRAM model: one-cycle read latency.
  logic [DATA_W-1:0] sram [ASPACE];
  always @(posedge clk) if (rd_en) rd_data <= sram[rd_addr];

  typedef struct { int addr; int cyc; } ae_t;
  typedef struct { int data; int idx; int cyc; } be_t;
  ae_t aq[$];
  be_t bq[$];
  int  words[$];     // reference FIFO contents
  int  n_chk  = 0;
  int  n_fail = 0;
  int  cyc    = 0;
  ae_t ma;
  be_t mb;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every strobe and every valid beat must match the next expectation.
  always @(negedge clk) begin
    if (rd_en) begin
      chk("strobe_expected", 64'(aq.size() != 0), 64'd1);
      if (aq.size() != 0) begin
        ma = aq.pop_front();
        chk("strobe_addr", 64'(rd_addr), 64'(ma.addr));
        chk("strobe_cycle", 64'(cyc), 64'(ma.cyc));
      end
    end
    if (pe_valid) begin
      chk("beat_expected", 64'(bq.size() != 0), 64'd1);
      if (bq.size() != 0) begin
        mb = bq.pop_front();
        chk("beat_data", 64'(pe_data), 64'(mb.data));
        chk("beat_idx", 64'(pe_idx), 64'(mb.idx));
        chk("beat_cycle", 64'(cyc), 64'(mb.cyc));
      end
    end
  end

  // Load a burst from 'b'; cycle 0 is the cycle the request is presented.
  task automatic do_load(input int b);
    int rise;
    for (int i = 0; i < DEPTH; i++) begin
      aq.push_back('{(b + i) % ASPACE, cyc + i});
      words.push_back(int'(sram[(b + i) % ASPACE]));
    end
    base = ADDR_W'(b);
    ctrl = 2'b01;
    rise = -1;
    for (int c = 0; c <= DEPTH + 2; c++) begin
      @(negedge clk);
      if (resp[0] && rise < 0) rise = c;
      tick();
      if (c == 0) begin
        ctrl = 2'b00;                 // request dropped: burst must continue
        base = ADDR_W'($urandom);     // must already be latched
      end
    end
    chk("load_latency", 64'(rise), 64'(DEPTH + 1));
    @(negedge clk);
    chk("full_count", 64'(count), 64'(DEPTH));
    chk("full_resp", 64'(resp), 64'd1);
    tick();
  endtask

  // mode 0: continuous, 1: toggled 1,0,1,0, 2: random
  task automatic do_drain(input int mode);
    int n, t, v;
    n = 0;
    t = 0;
    while (n < DEPTH && t < 200) begin
      v = (mode == 0) ? 1 : (mode == 1) ? int'(t % 2 == 0) : int'($urandom_range(1, 0));
      ctrl = {v[0], 1'b0};
      @(negedge clk);
      chk("drain_count", 64'(count), 64'(DEPTH - n));
      if (v != 0) begin
        bq.push_back('{words.pop_front(), n, cyc + 1});
        n++;
      end
      tick();
      t++;
    end
    chk("drain_beats", 64'(n), 64'(DEPTH));
    ctrl = 2'b00;
    tick();
    tick();
    @(negedge clk);
    chk("drain_done_resp", 64'(resp), 64'd2);
    chk("drain_done_count", 64'(count), 64'd0);
    chk("drain_beats_left", 64'(bq.size()), 64'd0);
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < ASPACE; i++) sram[i] = DATA_W'($urandom);
    rst  = 1'b1;
    ctrl = 2'b00;
    base = '0;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_resp", 64'(resp), 64'd0);
    chk("rst_rd_en", 64'(rd_en), 64'd0);
    chk("rst_valid", 64'(pe_valid), 64'd0);
    chk("rst_data", 64'(pe_data), 64'd0);
    chk("rst_idx", 64'(pe_idx), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    tick();

    // Basic burst and continuous drain
    do_load(32'h010);
    do_drain(0);

    // Load request while FULL is ignored (flagged when checking is built in)
    do_load(int'($urandom_range(ASPACE - 1, 0)));
    ctrl = 2'b01;
    tick();
    tick();
    tick();
    ctrl = 2'b00;
    @(negedge clk);
    chk("full_hold_count", 64'(count), 64'(DEPTH));
    chk("full_hold_resp", 64'(resp), 64'd1);
`ifdef IF_BUF_ERR_CHK_EN
    chk("err_flag", 64'(err), 64'd1);
    chk("err_code", 64'(err_code), 64'd2);
`endif
    tick();
    do_drain(1);

    // Address wrap across the top of SRAM
    do_load(32'h3FA);
    do_drain(2);

    // Drain request alone in IDLE: nothing happens
    ctrl = 2'b10;
    tick();
    tick();
    tick();
    ctrl = 2'b00;
    @(negedge clk);
    chk("idle_drain_resp", 64'(resp), 64'd2);
    chk("idle_drain_count", 64'(count), 64'd0);
`ifdef IF_BUF_ERR_CHK_EN
    chk("err_sticky_code", 64'(err_code), 64'd2);
`endif
    tick();

    // Load+drain together starts a load; reset in load cycle 7 aborts it
    base = ADDR_W'($urandom);
    for (int i = 0; i < 7; i++) aq.push_back('{(int'(base) + i) % ASPACE, cyc + i});
    ctrl = 2'b11;
    for (int c = 0; c < 7; c++) tick();
    rst  = 1'b1;
    ctrl = 2'b00;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_resp", 64'(resp), 64'd0);
    chk("abort_count", 64'(count), 64'd0);
    chk("abort_rd_en", 64'(rd_en), 64'd0);
    chk("abort_valid", 64'(pe_valid), 64'd0);
    chk("abort_data", 64'(pe_data), 64'd0);
    chk("abort_strobes_left", 64'(aq.size()), 64'd0);
    tick();

    // Randomized bursts after the abort
    for (int k = 0; k < 4; k++) begin
      do_load(int'($urandom_range(ASPACE - 1, 0)));
      do_drain(int'($urandom_range(2, 0)));
    end

    tick();
    tick();
    @(negedge clk);
    chk("final_strobes_left", 64'(aq.size()), 64'd0);
    chk("final_beats_left", 64'(bq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
